// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch opcodes, LEGv8 condition codes, the
// branch/flag unit state encoding and NZCV bit positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        BR_B    = 2'b00,
        BR_COND = 2'b01,
        BR_CBZ  = 2'b10,
        BR_CBNZ = 2'b11
    } br_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } bfu_state_t;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Bit positions inside the {N,Z,C,V} register
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

endpackage

// File: rtl/branch_flag_unit_if.sv
// Bundle between the pipeline (EX flags, ID branch) and the branch/flag unit.
interface branch_flag_unit_if
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic             ex_valid;
    logic             ex_setFlags;
    logic             alu_zero;
    logic             alu_negative;
    logic             alu_overflow;
    logic             alu_carryOut;
    logic             br_valid;
    br_op_t           br_op;
    logic [3:0]       br_cond;
    logic             rt_zero;
    logic             flush_in;
    logic             stall;
    logic             br_resolved;
    logic             br_taken;
    logic             flush_out;
    logic [3:0]       nzcv;
    logic [CNT_W-1:0] taken_count;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side: drives EX/ID information, consumes decisions
    modport master (
        output ex_valid, ex_setFlags, alu_zero, alu_negative, alu_overflow,
               alu_carryOut, br_valid, br_op, br_cond, rt_zero, flush_in,
        input  stall, br_resolved, br_taken, flush_out, nzcv,
               taken_count, stall_count
    );

    // Unit side
    modport slave (
        input  ex_valid, ex_setFlags, alu_zero, alu_negative, alu_overflow,
               alu_carryOut, br_valid, br_op, br_cond, rt_zero, flush_in,
        output stall, br_resolved, br_taken, flush_out, nzcv,
               taken_count, stall_count
    );
endinterface

// File: rtl/branch_flag_unit_cond_eval.sv
// LEGv8 condition-code evaluator: pass=1 when cond holds for the given NZCV.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic n, z, c, v;

    assign n = nzcv[NZCV_N];
    assign z = nzcv[NZCV_Z];
    assign c = nzcv[NZCV_C];
    assign v = nzcv[NZCV_V];

    // Decode the condition field against the flags
    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_HS: pass = c;
            COND_LO: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            default: pass = 1'b1;   // AL and NV both always taken
        endcase
    end
endmodule

// File: rtl/branch_flag_unit.sv
// Latches ALU flags into NZCV, resolves ID-stage branches and inserts a
// single stall when a B.cond depends on a flag-setter still in EX.
module branch_flag_unit
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
)(
    input  logic               clk,
    input  logic               reset,
    branch_flag_unit_if.slave  bfu
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    bfu_state_t       state_q, state_d;
    logic [3:0]       nzcv_q;
    logic [CNT_W-1:0] taken_count_q;
    logic [CNT_W-1:0] stall_count_q;

    logic cond_pass;
    logic hazard;
    logic stall;
    logic resolved;
    logic taken;

    // Single evaluator serves both IDLE and WAIT; in WAIT nzcv_q already
    // holds the producer's flags, so no forwarding path is needed.
    cond_eval u_cond_eval (
        .cond (bfu.br_cond),
        .nzcv (nzcv_q),
        .pass (cond_pass)
    );

    assign hazard = bfu.br_valid && (bfu.br_op == BR_COND) &&
                    bfu.ex_valid && bfu.ex_setFlags && !bfu.flush_in;

    // Branch direction for the opcode in ID
    always_comb begin
        taken = 1'b1;
        case (bfu.br_op)
            BR_B:    taken = 1'b1;
            BR_COND: taken = cond_pass;
            BR_CBZ:  taken = bfu.rt_zero;
            BR_CBNZ: taken = !bfu.rt_zero;
            default: taken = 1'b1;
        endcase
    end

    // Next state and stall/resolve decode
    always_comb begin
        state_d  = IDLE;
        stall    = 1'b0;
        resolved = 1'b0;
        case (state_q)
            IDLE: begin
                stall    = hazard;
                resolved = bfu.br_valid && !bfu.flush_in && !hazard;
                state_d  = hazard ? WAIT : IDLE;
            end
            WAIT: begin
                resolved = bfu.br_valid && !bfu.flush_in;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, flag register and saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            nzcv_q        <= 4'b0000;
            taken_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (bfu.ex_valid && bfu.ex_setFlags)
                nzcv_q <= {bfu.alu_negative, bfu.alu_zero,
                           bfu.alu_carryOut, bfu.alu_overflow};
            if (resolved && taken && (taken_count_q != CNT_MAX))
                taken_count_q <= taken_count_q + CNT_ONE;
            if (stall && (stall_count_q != CNT_MAX))
                stall_count_q <= stall_count_q + CNT_ONE;
        end
    end

    assign bfu.stall       = stall;
    assign bfu.br_resolved = resolved;
    assign bfu.br_taken    = taken;
    assign bfu.flush_out   = resolved & taken;
    assign bfu.nzcv        = nzcv_q;
    assign bfu.taken_count = taken_count_q;
    assign bfu.stall_count = stall_count_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit: a vector table of single-branch cases
// followed by hand-written multi-cycle sequences (hazard, flush, saturation,
// reset during a stall).
module tb_branch_flag_unit;
    import cpu_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_taken = 0;
    int   m_stall = 0;

    branch_flag_unit_if #(.CNT_W(CW)) bus_if ();

    branch_flag_unit #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (rst),
        .bfu   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nzcv;
        br_op_t     op;
        logic [3:0] cond;
        logic       rtz;
        logic       setter;
        logic       fl;
        logic       e_stall;
        logic       e_res;
        logic       e_taken;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] nz, br_op_t op, logic [3:0] cd,
                                logic rtz, logic st, logic fl,
                                logic es, logic er, logic et);
        vec_t v;
        v.nzcv = nz; v.op = op; v.cond = cd; v.rtz = rtz; v.setter = st;
        v.fl = fl; v.e_stall = es; v.e_res = er; v.e_taken = et;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.ex_valid = 0; bus_if.ex_setFlags = 0;
        bus_if.alu_zero = 0; bus_if.alu_negative = 0;
        bus_if.alu_overflow = 0; bus_if.alu_carryOut = 0;
        bus_if.br_valid = 0; bus_if.br_op = BR_B; bus_if.br_cond = 4'h0;
        bus_if.rt_zero = 0; bus_if.flush_in = 0;
    endtask

    task automatic set_flags(input logic [3:0] nz);
        bus_if.ex_valid = 1; bus_if.ex_setFlags = 1;
        bus_if.alu_negative = nz[3]; bus_if.alu_zero = nz[2];
        bus_if.alu_carryOut = nz[1]; bus_if.alu_overflow = nz[0];
    endtask

    task automatic branch(input br_op_t op, input logic [3:0] cd, input logic rtz);
        bus_if.br_valid = 1; bus_if.br_op = op; bus_if.br_cond = cd;
        bus_if.rt_zero = rtz;
    endtask

    task automatic do_reset();
        rst = 1; idle(); step(); step();
        rst = 0;
        m_taken = 0; m_stall = 0;
    endtask

    initial begin
        // ---------------- table ----------------
        vecs.push_back(mk(4'b0100, BR_COND, COND_EQ, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0000, BR_COND, COND_EQ, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b0100, BR_COND, COND_NE, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b0010, BR_COND, COND_HS, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0000, BR_COND, COND_LO, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b1000, BR_COND, COND_MI, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b1000, BR_COND, COND_PL, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b0001, BR_COND, COND_VS, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0001, BR_COND, COND_VC, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b0010, BR_COND, COND_HI, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0110, BR_COND, COND_HI, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b0110, BR_COND, COND_LS, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0010, BR_COND, COND_LS, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b1001, BR_COND, COND_GE, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b1000, BR_COND, COND_GE, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b1000, BR_COND, COND_LT, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0000, BR_COND, COND_GT, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0100, BR_COND, COND_GT, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b0001, BR_COND, COND_LE, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0000, BR_COND, COND_LE, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b0000, BR_COND, COND_AL, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0000, BR_COND, COND_NV, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0000, BR_B,    4'h0,    0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0000, BR_CBZ,  4'h0,    1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0000, BR_CBZ,  4'h0,    0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b0000, BR_CBNZ, 4'h0,    0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0000, BR_CBNZ, 4'h0,    1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b0100, BR_COND, COND_EQ, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(4'b0000, BR_B,    4'h0,    0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(4'b0000, BR_COND, COND_AL, 0, 1, 1, 0, 0, 0));

        // ---------------- S1: reset state and first capture ----------------
        do_reset();
        #2;
        chk("rst_nzcv", bus_if.nzcv, 4'b0000);
        chk("rst_taken_cnt", bus_if.taken_count, 0);
        chk("rst_stall_cnt", bus_if.stall_count, 0);
        chk("rst_stall", bus_if.stall, 0);
        chk("rst_resolved", bus_if.br_resolved, 0);
        set_flags(4'b0110);                       // SUBS: Z=1, C=1
        step();
        idle(); branch(BR_COND, COND_EQ, 0); #2;
        chk("s1_nzcv", bus_if.nzcv, 4'b0110);
        chk("s1_resolved", bus_if.br_resolved, 1);
        chk("s1_taken", bus_if.br_taken, 1);
        chk("s1_flush_out", bus_if.flush_out, 1);
        chk("s1_stall", bus_if.stall, 0);
        chk("s1_taken_cnt_pre", bus_if.taken_count, 0);
        step();
        idle(); #2;
        chk("s1_taken_cnt", bus_if.taken_count, 1);

        // ---------------- S2: ADDS N=1 + B.GE hazard ----------------
        set_flags(4'b1000); branch(BR_COND, COND_GE, 0); #2;
        chk("s2_t_stall", bus_if.stall, 1);
        chk("s2_t_resolved", bus_if.br_resolved, 0);
        chk("s2_t_flush_out", bus_if.flush_out, 0);
        step();
        bus_if.ex_valid = 0; bus_if.ex_setFlags = 0; #2;
        chk("s2_t1_stall", bus_if.stall, 0);
        chk("s2_t1_resolved", bus_if.br_resolved, 1);
        chk("s2_t1_taken", bus_if.br_taken, 0);
        chk("s2_t1_nzcv", bus_if.nzcv, 4'b1000);
        step();
        idle(); #2;
        chk("s2_stall_cnt", bus_if.stall_count, 1);
        chk("s2_taken_cnt", bus_if.taken_count, 1);

        // ---------------- S3: hazard then flush in WAIT ----------------
        set_flags(4'b0000); branch(BR_COND, COND_GE, 0); #2;
        chk("s3_stall", bus_if.stall, 1);
        step();
        bus_if.ex_valid = 0; bus_if.ex_setFlags = 0; bus_if.flush_in = 1; #2;
        chk("s3_w_resolved", bus_if.br_resolved, 0);
        chk("s3_w_flush_out", bus_if.flush_out, 0);
        step();
        // a fresh hazard stalls only if the unit went back to IDLE
        idle(); set_flags(4'b0000); branch(BR_COND, COND_AL, 0); #2;
        chk("s3_idle_stall", bus_if.stall, 1);
        chk("s3_taken_cnt", bus_if.taken_count, 1);
        chk("s3_stall_cnt", bus_if.stall_count, 2);
        step();
        idle(); step();

        // ---------------- S4: taken_count saturation (CNT_W=4) ----------------
        do_reset();
        for (int i = 0; i < 15; i++) begin
            branch(BR_B, 4'h0, 0);
            step();
        end
        idle(); #2;
        chk("s4_taken_cnt_15", bus_if.taken_count, 15);
        branch(BR_B, 4'h0, 0); #2;
        chk("s4_extra_resolved", bus_if.br_resolved, 1);
        step();
        idle(); #2;
        chk("s4_taken_cnt_sat", bus_if.taken_count, 15);

        // ---------------- S5: reset during WAIT ----------------
        set_flags(4'b1111); branch(BR_COND, COND_EQ, 0); #2;
        chk("s5_stall", bus_if.stall, 1);
        step();
        #2;
        chk("s5_wait_stall_cnt", bus_if.stall_count, 1);
        rst = 1;                                  // flag-setter still present
        step();
        rst = 0; idle(); #2;
        chk("s5_nzcv", bus_if.nzcv, 4'b0000);
        chk("s5_taken_cnt", bus_if.taken_count, 0);
        chk("s5_stall_cnt", bus_if.stall_count, 0);
        set_flags(4'b0000); branch(BR_COND, COND_EQ, 0); #2;
        chk("s5_idle_stall", bus_if.stall, 1);
        step();
        idle(); step();

        // ---------------- table run ----------------
        do_reset();
        foreach (vecs[k]) begin
            idle(); set_flags(vecs[k].nzcv);
            step();
            idle();
            bus_if.ex_valid = vecs[k].setter; bus_if.ex_setFlags = vecs[k].setter;
            bus_if.flush_in = vecs[k].fl;
            branch(vecs[k].op, vecs[k].cond, vecs[k].rtz);
            #2;
            chk($sformatf("v%0d_nzcv", k), bus_if.nzcv, vecs[k].nzcv);
            chk($sformatf("v%0d_stall", k), bus_if.stall, vecs[k].e_stall);
            chk($sformatf("v%0d_resolved", k), bus_if.br_resolved, vecs[k].e_res);
            chk($sformatf("v%0d_flush_out", k), bus_if.flush_out,
                vecs[k].e_res & vecs[k].e_taken);
            if (vecs[k].e_res)
                chk($sformatf("v%0d_taken", k), bus_if.br_taken, vecs[k].e_taken);
            if (vecs[k].e_res && vecs[k].e_taken && m_taken < 15) m_taken++;
            if (vecs[k].e_stall && m_stall < 15) m_stall++;
            step();
            idle(); #2;
            chk($sformatf("v%0d_taken_cnt", k), bus_if.taken_count, m_taken);
            chk($sformatf("v%0d_stall_cnt", k), bus_if.stall_count, m_stall);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
